// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pkg
//  Description : Shared definitions for the snake body engine: one-hot
//                direction codes, direction helpers, FSM state encoding and
//                default colour ids.
//  Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // One-hot direction codes as presented on the dir input.
    localparam logic [3:0] c_dir_right = 4'b0001;
    localparam logic [3:0] c_dir_left  = 4'b0010;
    localparam logic [3:0] c_dir_down  = 4'b0100;
    localparam logic [3:0] c_dir_up    = 4'b1000;

    // Default colour ids.
    localparam logic [7:0] c_color_head = 8'hff;
    localparam logic [7:0] c_color_body = 8'h0f;
    localparam logic [7:0] c_color_bg   = 8'h00;

    // Engine state encoding.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SCAN  = 3'd2,
        ST_ERASE = 3'd3,
        ST_BODY  = 3'd4,
        ST_HEAD  = 3'd5,
        ST_DEAD  = 3'd6
    } state_t;

    // Opposite heading of a one-hot direction.
    function automatic logic [3:0] reverse_dir(input logic [3:0] d);
        logic [3:0] r;
        r = d;
        case (d)
            c_dir_right: r = c_dir_left;
            c_dir_left:  r = c_dir_right;
            c_dir_down:  r = c_dir_up;
            c_dir_up:    r = c_dir_down;
            default:     r = d;
        endcase
        return r;
    endfunction

    // True when exactly one of the four request bits is set.
    function automatic logic is_onehot4(input logic [3:0] d);
        return (d == c_dir_right) || (d == c_dir_left) ||
               (d == c_dir_down)  || (d == c_dir_up);
    endfunction

endpackage : snake_pkg
`default_nettype wire

// File: rtl/snake_seg_ram.sv
`default_nettype none
// ============================================================================
//  Module      : snake_seg_ram
//  Description : Ring storage for snake segment coordinates. Synchronous
//                write, combinational read by index.
//  Ports       : clk        - system clock
//                i_wr_en    - write strobe
//                i_wr_addr  - write index
//                i_wr_data  - packed {x, y} written at i_wr_addr
//                i_rd_addr  - read index
//                o_rd_data  - packed {x, y} stored at i_rd_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_seg_ram #(
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : snake_seg_ram
`default_nettype wire

// File: rtl/snake_body_engine.sv
`default_nettype none
// ============================================================================
//  Module      : snake_body_engine
//  Description : Multi-segment snake mover. Keeps the body in a ring buffer,
//                accepts direction requests and step ticks, detects self and
//                wall collisions and redraws each move incrementally through
//                a one-outstanding request/done draw handshake.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                step              - one-cycle move tick (taken in IDLE only)
//                dir               - one-hot direction request
//                grow              - one-cycle apple-eaten pulse
//                draw_done         - completion of the outstanding draw
//                head_x, head_y    - current head position
//                length            - current segment count
//                busy              - move or draw sequence in progress
//                game_over         - sticky collision flag
//                draw_x/y/color    - draw request payload
//                draw_vld          - one-cycle draw request strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int H_LOGIC_WIDTH  = 5,
    parameter int V_LOGIC_WIDTH  = 5,
    parameter int H_LOGIC_MAX    = 31,
    parameter int V_LOGIC_MAX    = 23,
    parameter int MAX_LEN        = 64,
    parameter int LEN_WIDTH      = 7,
    parameter int INIT_X         = 16,
    parameter int INIT_Y         = 12,
    parameter int WRAP           = 1,
    parameter int COLOR_ID_WIDTH = 8,
    parameter logic [COLOR_ID_WIDTH-1:0] COLOR_HEAD = c_color_head,
    parameter logic [COLOR_ID_WIDTH-1:0] COLOR_BODY = c_color_body,
    parameter logic [COLOR_ID_WIDTH-1:0] COLOR_BG   = c_color_bg
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step,
    input  logic [3:0]                dir,
    input  logic                      grow,
    input  logic                      draw_done,
    output logic [H_LOGIC_WIDTH-1:0]  head_x,
    output logic [V_LOGIC_WIDTH-1:0]  head_y,
    output logic [LEN_WIDTH-1:0]      length,
    output logic                      busy,
    output logic                      game_over,
    output logic [H_LOGIC_WIDTH-1:0]  draw_x,
    output logic [V_LOGIC_WIDTH-1:0]  draw_y,
    output logic [COLOR_ID_WIDTH-1:0] draw_color,
    output logic                      draw_vld
);

    localparam int c_ptr_w = $clog2(MAX_LEN);
    localparam int c_seg_w = H_LOGIC_WIDTH + V_LOGIC_WIDTH;

    localparam logic [H_LOGIC_WIDTH-1:0] c_h_max  = H_LOGIC_WIDTH'(H_LOGIC_MAX);
    localparam logic [V_LOGIC_WIDTH-1:0] c_v_max  = V_LOGIC_WIDTH'(V_LOGIC_MAX);
    localparam logic [H_LOGIC_WIDTH-1:0] c_init_x = H_LOGIC_WIDTH'(INIT_X);
    localparam logic [V_LOGIC_WIDTH-1:0] c_init_y = V_LOGIC_WIDTH'(INIT_Y);
    localparam logic [H_LOGIC_WIDTH-1:0] c_x_one  = H_LOGIC_WIDTH'(1);
    localparam logic [V_LOGIC_WIDTH-1:0] c_y_one  = V_LOGIC_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]     c_len_1  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]     c_len_2  = LEN_WIDTH'(2);
    localparam logic [LEN_WIDTH-1:0]     c_len_mx = LEN_WIDTH'(MAX_LEN);
    localparam logic [c_ptr_w-1:0]       c_ptr_1  = c_ptr_w'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                      r_state;
    state_t                      w_state_next;

    logic [c_ptr_w-1:0]          r_head_ptr;
    logic [c_ptr_w-1:0]          r_tail_ptr;
    logic [c_ptr_w-1:0]          r_scan_idx;
    logic [LEN_WIDTH-1:0]        r_length;
    logic [LEN_WIDTH-1:0]        r_scan_cnt;
    logic [3:0]                  r_cur_dir;
    logic [3:0]                  r_pend_dir;
    logic                        r_grow_pending;
    logic                        r_growing;
    logic                        r_game_over;
    logic                        r_issued;

    logic [H_LOGIC_WIDTH-1:0]    r_head_x, r_next_x, r_old_x, r_tail_x;
    logic [V_LOGIC_WIDTH-1:0]    r_head_y, r_next_y, r_old_y, r_tail_y;

    logic                        r_draw_vld;
    logic [H_LOGIC_WIDTH-1:0]    r_draw_x;
    logic [V_LOGIC_WIDTH-1:0]    r_draw_y;
    logic [COLOR_ID_WIDTH-1:0]   r_draw_color;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [H_LOGIC_WIDTH-1:0]    w_next_x;
    logic [V_LOGIC_WIDTH-1:0]    w_next_y;
    logic                        w_wall;
    logic                        w_accept;
    logic                        w_grow_eff;
    logic [LEN_WIDTH-1:0]        w_scan_cnt;
    logic                        w_issue;
    logic                        w_done_ok;
    logic                        w_hit;
    logic                        w_commit;
    logic [H_LOGIC_WIDTH-1:0]    w_draw_x;
    logic [V_LOGIC_WIDTH-1:0]    w_draw_y;
    logic [COLOR_ID_WIDTH-1:0]   w_draw_color;
    logic                        w_wr_en;
    logic [c_ptr_w-1:0]          w_wr_addr;
    logic [c_seg_w-1:0]          w_wr_data;
    logic [c_ptr_w-1:0]          w_rd_addr;
    logic [c_seg_w-1:0]          w_rd_data;

    // ------------------------------------------------------------------
    // Segment storage
    // ------------------------------------------------------------------
    // INIT keeps writing the reset head into its slot so the ring always
    // holds a valid entry for the first move. At commit the new head goes
    // one slot past the current head.
    assign w_wr_en   = w_commit || (r_state == ST_INIT);
    assign w_wr_addr = w_commit ? (r_head_ptr + c_ptr_1) : r_head_ptr;
    assign w_wr_data = w_commit ? {r_next_x, r_next_y} : {r_head_x, r_head_y};

    // The single read port walks the body during SCAN; otherwise it points
    // at the tail so the tail coordinate can be captured on step accept,
    // before a full-length commit overwrites that slot.
    assign w_rd_addr = (r_state == ST_SCAN) ? r_scan_idx : r_tail_ptr;

    snake_seg_ram #(
        .DEPTH      (MAX_LEN),
        .ADDR_WIDTH (c_ptr_w),
        .DATA_WIDTH (c_seg_w)
    ) u_seg_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // ------------------------------------------------------------------
    // Next head position and wall detection
    // ------------------------------------------------------------------
    always_comb begin
        w_next_x = r_head_x;
        w_next_y = r_head_y;
        w_wall   = 1'b0;
        case (r_pend_dir)
            c_dir_right: begin
                if (r_head_x == c_h_max) begin
                    w_next_x = '0;
                    w_wall   = (WRAP == 0);
                end else begin
                    w_next_x = r_head_x + c_x_one;
                end
            end
            c_dir_left: begin
                if (r_head_x == '0) begin
                    w_next_x = c_h_max;
                    w_wall   = (WRAP == 0);
                end else begin
                    w_next_x = r_head_x - c_x_one;
                end
            end
            c_dir_down: begin
                if (r_head_y == c_v_max) begin
                    w_next_y = '0;
                    w_wall   = (WRAP == 0);
                end else begin
                    w_next_y = r_head_y + c_y_one;
                end
            end
            c_dir_up: begin
                if (r_head_y == '0) begin
                    w_next_y = c_v_max;
                    w_wall   = (WRAP == 0);
                end else begin
                    w_next_y = r_head_y - c_y_one;
                end
            end
            default: begin
                w_next_x = r_head_x;
                w_next_y = r_head_y;
            end
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && step;

    // A grow arriving together with the step is consumed by that step.
    // Growth at full length is dropped, so such a move behaves exactly like
    // a normal one (tail excluded from the scan, tail erased).
    assign w_grow_eff = (r_grow_pending || grow) && (r_length < c_len_mx);

    // Entries to compare, walking from the segment behind the head toward
    // the tail. The head itself is never a candidate; the tail is skipped
    // when it is about to vacate.
    always_comb begin
        if (w_grow_eff) begin
            w_scan_cnt = r_length - c_len_1;
        end else if (r_length >= c_len_2) begin
            w_scan_cnt = r_length - c_len_2;
        end else begin
            w_scan_cnt = '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and draw request selection
    // ------------------------------------------------------------------
    // A late done (e.g. from before a reset) must not complete a request
    // that has only just been strobed, hence the !r_draw_vld qualifier.
    assign w_done_ok = r_issued && !r_draw_vld && draw_done;

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_hit        = 1'b0;
        w_commit     = 1'b0;
        w_draw_x     = r_head_x;
        w_draw_y     = r_head_y;
        w_draw_color = COLOR_HEAD;
        case (r_state)
            ST_INIT: begin
                w_issue = !r_issued;
                if (w_done_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (step) begin
                    w_state_next = w_wall ? ST_DEAD : ST_SCAN;
                end
            end
            ST_SCAN: begin
                // A zero count still spends one cycle here, without comparing.
                w_hit = (r_scan_cnt != '0) && (w_rd_data == {r_next_x, r_next_y});
                if (w_hit) begin
                    w_state_next = ST_DEAD;
                end else if (r_scan_cnt <= c_len_1) begin
                    w_commit     = 1'b1;
                    w_state_next = r_growing ? ST_BODY : ST_ERASE;
                end
            end
            ST_ERASE: begin
                w_issue      = !r_issued;
                w_draw_x     = r_tail_x;
                w_draw_y     = r_tail_y;
                w_draw_color = COLOR_BG;
                if (w_done_ok) begin
                    // r_length already holds the post-move length here.
                    w_state_next = (r_length > c_len_1) ? ST_BODY : ST_HEAD;
                end
            end
            ST_BODY: begin
                w_issue      = !r_issued;
                w_draw_x     = r_old_x;
                w_draw_y     = r_old_y;
                w_draw_color = COLOR_BODY;
                if (w_done_ok) begin
                    w_state_next = ST_HEAD;
                end
            end
            ST_HEAD: begin
                w_issue = !r_issued;
                if (w_done_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_DEAD: begin
                w_state_next = ST_DEAD;
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_ptr     <= '0;
            r_tail_ptr     <= '0;
            r_scan_idx     <= '0;
            r_scan_cnt     <= '0;
            r_length       <= c_len_1;
            r_cur_dir      <= c_dir_right;
            r_pend_dir     <= c_dir_right;
            r_grow_pending <= 1'b0;
            r_growing      <= 1'b0;
            r_game_over    <= 1'b0;
            r_issued       <= 1'b0;
            r_head_x       <= c_init_x;
            r_head_y       <= c_init_y;
            r_next_x       <= '0;
            r_next_y       <= '0;
            r_old_x        <= '0;
            r_old_y        <= '0;
            r_tail_x       <= '0;
            r_tail_y       <= '0;
            r_draw_vld     <= 1'b0;
            r_draw_x       <= '0;
            r_draw_y       <= '0;
            r_draw_color   <= '0;
        end else begin
            // Draw handshake: one strobe per state visit, then wait for done.
            r_draw_vld <= w_issue;
            if (w_issue) begin
                r_issued     <= 1'b1;
                r_draw_x     <= w_draw_x;
                r_draw_y     <= w_draw_y;
                r_draw_color <= w_draw_color;
            end else if (w_done_ok) begin
                r_issued <= 1'b0;
            end

            // Direction request filtering; the reverse check is against the
            // heading actually in use, not the pending one.
            if ((r_state != ST_DEAD) && is_onehot4(dir) &&
                ((dir != reverse_dir(r_cur_dir)) || (r_length == c_len_1))) begin
                r_pend_dir <= dir;
            end

            if (r_state != ST_DEAD) begin
                if (w_accept) begin
                    r_grow_pending <= 1'b0;
                end else if (grow) begin
                    r_grow_pending <= 1'b1;
                end
            end

            if (w_accept) begin
                r_cur_dir  <= r_pend_dir;
                r_next_x   <= w_next_x;
                r_next_y   <= w_next_y;
                r_old_x    <= r_head_x;
                r_old_y    <= r_head_y;
                r_tail_x   <= w_rd_data[c_seg_w-1 -: H_LOGIC_WIDTH];
                r_tail_y   <= w_rd_data[V_LOGIC_WIDTH-1:0];
                r_growing  <= w_grow_eff;
                r_scan_idx <= r_head_ptr - c_ptr_1;
                r_scan_cnt <= w_scan_cnt;
            end

            if ((r_state == ST_SCAN) && !w_hit && !w_commit) begin
                r_scan_idx <= r_scan_idx - c_ptr_1;
                r_scan_cnt <= r_scan_cnt - c_len_1;
            end

            if (w_commit) begin
                r_head_ptr <= r_head_ptr + c_ptr_1;
                r_head_x   <= r_next_x;
                r_head_y   <= r_next_y;
                if (r_growing) begin
                    r_length <= r_length + c_len_1;
                end else begin
                    r_tail_ptr <= r_tail_ptr + c_ptr_1;
                end
            end

            if ((w_accept && w_wall) || w_hit) begin
                r_game_over <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign head_x     = r_head_x;
    assign head_y     = r_head_y;
    assign length     = r_length;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DEAD);
    assign game_over  = r_game_over;
    assign draw_x     = r_draw_x;
    assign draw_y     = r_draw_y;
    assign draw_color = r_draw_color;
    assign draw_vld   = r_draw_vld;

endmodule : snake_body_engine
`default_nettype wire

// File: doc/snake_body_engine.md
Name: snake_body_engine

Overview:
Parametrised successor to the single-segment snake mover. Holds the full snake body in a ring buffer of up to MAX_LEN segments and accepts a direction and a step tick. It detects self-collision and, when WRAP=0, wall collision. Each move is drawn incrementally through the draw_superpixel request/done handshake: tail erase, old-head recolour, then new head. Sits between the tick generator / key logic and draw_superpixel; the Apple block drives grow.

Parameters:
H_LOGIC_WIDTH, 5, x coordinate width
V_LOGIC_WIDTH, 5, y coordinate width
H_LOGIC_MAX, 31, last logic column
V_LOGIC_MAX, 23, last logic row
MAX_LEN, 64, ring-buffer depth (max segments), power of two
LEN_WIDTH, 7, width of length, >= clog2(MAX_LEN+1)
INIT_X, 16, head x after reset
INIT_Y, 12, head y after reset
WRAP, 1, 1 = wrap at edges; 0 = leaving the field ends the game
COLOR_ID_WIDTH, 8, colour id width
COLOR_HEAD, 8'hff, head colour
COLOR_BODY, 8'h0f, body colour
COLOR_BG, 8'h00, erase colour

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  synchronous active-high reset
step  in  1  one-cycle move tick
dir  in  4  one-hot request: bit0 right, bit1 left, bit2 down, bit3 up
grow  in  1  one-cycle pulse, apple eaten
draw_done  in  1  draw_superpixel odone
head_x  out  H_LOGIC_WIDTH  current head column
head_y  out  V_LOGIC_WIDTH  current head row
length  out  LEN_WIDTH  current segment count
busy  out  1  move or draw sequence in progress
game_over  out  1  sticky collision flag
draw_x  out  H_LOGIC_WIDTH  draw request column
draw_y  out  V_LOGIC_WIDTH  draw request row
draw_color  out  COLOR_ID_WIDTH  draw request colour
draw_vld  out  1  one-cycle draw request strobe

Behaviour:
- Reset:
  - length=1; head=(INIT_X,INIT_Y); current direction=right; grow_pending=0; game_over=0; draw_vld=0.
  - FSM enters INIT and issues one head draw; busy=1 until its draw_done.
- States: INIT, IDLE, SCAN, ERASE, BODY, HEAD, DEAD.
- Draw handshake:
  - draw_vld is high for exactly one cycle, with draw_x/y/color valid in the same cycle.
  - The FSM then waits for draw_done before the next request. At most one request is outstanding.
- Steps and busy:
  - step is accepted only in IDLE; a step in any other state is dropped.
  - busy=1 in every state except IDLE and DEAD.
- Direction handling:
  - dir is sampled every cycle.
  - It updates the pending direction only if exactly one bit is set and it is not the reverse of the current direction (reverse is allowed when length==1).
  - The pending direction becomes current when a step is accepted.
- grow handling:
  - A grow pulse in any state sets grow_pending.
  - grow_pending is consumed by the next accepted step.
  - Multiple grows before a step collapse to one.
- Next head:
  - Computed from the current head on step acceptance.
  - WRAP=1: 0 - 1 wraps to MAX, MAX + 1 wraps to 0, per axis.
  - WRAP=0: leaving the field sets game_over and goes to DEAD, with no draws.
- SCAN:
  - Compares the next head against one ring entry per cycle, walking from head toward tail.
  - If not growing, the tail entry is excluded, so moving into the vacating tail is legal.
  - Duration = length-1 cycles if growing, length-2 otherwise (minimum 1 cycle).
  - A hit sets game_over and goes to DEAD; no buffer write.
- Commit (last SCAN cycle, no hit):
  - Write the next head at head_ptr+1 (mod MAX_LEN) and advance head_ptr.
  - If growing and length<MAX_LEN: length+1 and the tail pointer holds.
  - Otherwise the tail pointer advances. Growth at MAX_LEN is discarded.
- Draw order after commit:
  - ERASE: old tail with COLOR_BG; skipped when growing.
  - BODY: old head with COLOR_BODY; skipped when the new length==1.
  - HEAD: new head with COLOR_HEAD.
  - Return to IDLE.
- Outputs: head_x/head_y/length update at commit.
- DEAD: holds until rst; step, dir and grow are ignored.
- Reset mid-sequence: an outstanding draw_done is ignored. The partially drawn screen is cleared by the top level, not by this block.

Decomposition:
- Package snake_pkg holds:
  - direction bit constants and the reverse-direction function;
  - the FSM state enum;
  - default colour ids.
- Sub-module snake_seg_ram: MAX_LEN x (H+V) ring storage with synchronous write and combinational read by index. Pointers and the FSM stay in snake_body_engine.

Test Plan:
- Reset, then draw_done 2 cycles after each draw_vld -> one draw at (16,12) colour ff; length=1; busy falls; then idle.
- length 1, dir=right, step -> erase (16,12) 00, head (17,12) ff; no BODY draw; head_x=17.
- grow then step, dir=down from (17,12) -> no erase, body (17,12) 0f, head (17,13) ff; length=2.
- WRAP=1, head (31,5), dir=right, step -> head (0,5). WRAP=0, same setup -> game_over=1, zero draw_vld.
- Grow to length 5; steps right, down, left, up -> the up step hits its own body: game_over=1, no draws, later steps ignored.
- dir=left while moving right at length 3 -> ignored, head moves right. step while busy -> dropped, exactly one move per accepted step.
